// File: rtl/unified_mem_arbiter.sv
// Single-port RAM arbiter shared by the fetch and memory pipeline stages.
// Same-cycle grant, tagged read-return pipe and anti-starvation fairness FSM.
module unified_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int MAX_STREAK = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_rvalid,
    output logic [DW-1:0] mem_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    // state     | meaning
    // S_MEM_PRI | memory stage wins a conflict (default)
    // S_IF_PRI  | fetch wins a conflict after MAX_STREAK memory grants
    typedef enum logic {
        S_MEM_PRI = 1'b0,
        S_IF_PRI  = 1'b1
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t              state_q, state_d;
    logic [3:0]          streak_q, streak_d;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       if_rdata_q, mem_rdata_q;
    logic [RD_LAT-1:0]   tag_vld_q, tag_mem_q;
    logic                push_vld, push_mem;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_MEM_PRI;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Next-state logic; the streak compare uses the updated count so that
    // fetch wins the cycle right after the MAX_STREAK-th memory grant.
    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = 4'd0;
        end else if (mem_gnt && streak_q != 4'hF) begin
            streak_d = streak_q + 4'd1;
        end

        state_d = state_q;
        case (state_q)
            S_MEM_PRI: if (streak_d == STREAK_MAX) state_d = S_IF_PRI;
            S_IF_PRI:  if (if_gnt || !if_req)      state_d = S_MEM_PRI;
            default:                               state_d = S_MEM_PRI;
        endcase
    end

    // Output logic: grants
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (rst_n) begin
            if (if_req && mem_req) begin
                if (state_q == S_IF_PRI) if_gnt  = 1'b1;
                else                     mem_gnt = 1'b1;
            end else begin
                if_gnt  = if_req;
                mem_gnt = mem_req;
            end
        end
    end

    assign stall_if  = rst_n & if_req  & ~if_gnt;
    assign stall_mem = rst_n & mem_req & ~mem_gnt;

    always_comb begin
        ram_addr = addr_q;
        if (!rst_n)       ram_addr = '0;
        else if (if_gnt)  ram_addr = if_addr;
        else if (mem_gnt) ram_addr = mem_addr;
    end

    assign ram_we    = mem_gnt & mem_we;
    assign ram_wdata = rst_n ? mem_wdata : '0;

    assign push_vld = if_gnt | (mem_gnt & ~mem_we);
    assign push_mem = mem_gnt;

    // Tag pipe: one stage per cycle of RAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_mem_q <= '0;
        end else begin
            tag_vld_q[0] <= push_vld;
            tag_mem_q[0] <= push_mem;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_mem_q[i] <= tag_mem_q[i-1];
            end
        end
    end

    assign if_rvalid  = rst_n & tag_vld_q[RD_LAT-1] & ~tag_mem_q[RD_LAT-1];
    assign mem_rvalid = rst_n & tag_vld_q[RD_LAT-1] &  tag_mem_q[RD_LAT-1];

    assign if_rdata  = !rst_n ? '0 : (if_rvalid  ? ram_rdata : if_rdata_q);
    assign mem_rdata = !rst_n ? '0 : (mem_rvalid ? ram_rdata : mem_rdata_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if (if_gnt || mem_gnt) addr_q      <= ram_addr;
            if (if_rvalid)         if_rdata_q  <= ram_rdata;
            if (mem_rvalid)        mem_rdata_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a write-first, 1-cycle RAM model.
module tb_unified_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, mem_req, mem_we;
    logic [AW-1:0] if_addr, mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_we;
    logic          stall_if, stall_mem;
    logic [DW-1:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_STREAK(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // RAM model: write-first, one-cycle read latency, preloaded on the first edge.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic          ram_init = 1'b0;
    logic [DW-1:0] rd_q;
    assign ram_rdata = rd_q;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= 32'hA5A50000 | i;
            ram_mem[10'h004] <= 32'h8C010000;
            ram_mem[10'h008] <= 32'h0000F008;
            ram_mem[10'h010] <= 32'h11112222;
            ram_mem[10'h030] <= 32'h33330030;
            ram_init <= 1'b1;
            rd_q     <= '0;
        end else begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            rd_q <= ram_we ? ram_wdata : ram_mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic mr, input logic mw, input logic [AW-1:0] ma,
                         input logic [DW-1:0] wd);
        if_req = ir; if_addr = ia;
        mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = wd;
        #1;
    endtask

    string pat;
    int    prev_g;
    int    cur_g;

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 10'h008, 1'b1, 1'b0, 10'h010, 32'h0);

        // Reset held two cycles with both requesting
        for (int k = 0; k < 2; k++) begin
            cyc();
            drive(1'b1, 10'h008, 1'b1, 1'b0, 10'h010, 32'h0);
            chk("rst_if_gnt",    32'(if_gnt), 0);
            chk("rst_mem_gnt",   32'(mem_gnt), 0);
            chk("rst_stall_if",  32'(stall_if), 0);
            chk("rst_stall_mem", 32'(stall_mem), 0);
            chk("rst_ram_we",    32'(ram_we), 0);
            chk("rst_ram_addr",  32'(ram_addr), 0);
            chk("rst_rvalid",    32'({if_rvalid, mem_rvalid}), 0);
            chk("rst_if_rdata",  if_rdata, 0);
        end

        // First cycle after release: conflict, memory wins
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 10'h008, 1'b1, 1'b0, 10'h010, 32'h0);
        chk("rel_mem_gnt",  32'(mem_gnt), 1);
        chk("rel_if_gnt",   32'(if_gnt), 0);
        chk("rel_stall_if", 32'(stall_if), 1);
        chk("rel_ram_addr", 32'(ram_addr), 32'h010);

        cyc();
        drive(1'b1, 10'h008, 1'b0, 1'b0, 10'h010, 32'h0);
        chk("cf_if_gnt",     32'(if_gnt), 1);
        chk("cf_stall_if",   32'(stall_if), 0);
        chk("cf_mem_rvalid", 32'(mem_rvalid), 1);
        chk("cf_mem_rdata",  mem_rdata, 32'h11112222);
        chk("cf_if_rvalid",  32'(if_rvalid), 0);

        cyc();
        drive(1'b0, 10'h008, 1'b0, 1'b0, 10'h010, 32'h0);
        chk("cf_if_rvalid2", 32'(if_rvalid), 1);
        chk("cf_if_rdata",   if_rdata, 32'h0000F008);
        chk("cf_mem_hold",   mem_rdata, 32'h11112222);
        chk("cf_mem_rv0",    32'(mem_rvalid), 0);
        chk("idle_addr_hold", 32'(ram_addr), 32'h008);

        // Single fetch
        cyc();
        drive(1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0);
        chk("sf_if_gnt",   32'(if_gnt), 1);
        chk("sf_ram_addr", 32'(ram_addr), 32'h004);
        chk("sf_ram_we",   32'(ram_we), 0);
        cyc();
        drive(1'b0, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0);
        chk("sf_if_rvalid", 32'(if_rvalid), 1);
        chk("sf_if_rdata",  if_rdata, 32'h8C010000);
        chk("sf_mem_hold",  mem_rdata, 32'h11112222);
        cyc();
        drive(1'b0, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0);
        chk("sf_rvalid_off", 32'({if_rvalid, mem_rvalid}), 0);

        // Starvation: both held 8 cycles
        pat    = "MMMIMMMI";
        prev_g = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            drive(1'b1, 10'h008, 1'b1, 1'b0, 10'h030, 32'h0);
            cur_g = (pat[k] == "M") ? 1 : 2;
            chk($sformatf("sv_mem_gnt%0d", k),   32'(mem_gnt),   (cur_g == 1) ? 1 : 0);
            chk($sformatf("sv_if_gnt%0d", k),    32'(if_gnt),    (cur_g == 2) ? 1 : 0);
            chk($sformatf("sv_stall_mem%0d", k), 32'(stall_mem), (cur_g == 2) ? 1 : 0);
            chk($sformatf("sv_mem_rv%0d", k),    32'(mem_rvalid), (prev_g == 1) ? 1 : 0);
            chk($sformatf("sv_if_rv%0d", k),     32'(if_rvalid),  (prev_g == 2) ? 1 : 0);
            if (prev_g == 1) chk($sformatf("sv_mem_rd%0d", k), mem_rdata, 32'h33330030);
            if (prev_g == 2) chk($sformatf("sv_if_rd%0d", k),  if_rdata,  32'h0000F008);
            prev_g = cur_g;
        end
        cyc();
        drive(1'b0, 10'h008, 1'b0, 1'b0, 10'h030, 32'h0);
        chk("sv_last_if_rv", 32'(if_rvalid), 1);
        chk("sv_last_mem_rv", 32'(mem_rvalid), 0);

        // Write then read of same address
        cyc();
        drive(1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 32'hDEADBEEF);
        chk("wr_mem_gnt",   32'(mem_gnt), 1);
        chk("wr_ram_we",    32'(ram_we), 1);
        chk("wr_ram_addr",  32'(ram_addr), 32'h020);
        chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
        cyc();
        drive(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 32'h0);
        chk("rd_ram_we",     32'(ram_we), 0);
        chk("wr_no_rvalid",  32'(mem_rvalid), 0);
        chk("rd_mem_gnt",    32'(mem_gnt), 1);
        cyc();
        drive(1'b0, 10'h000, 1'b0, 1'b0, 10'h020, 32'h0);
        chk("rd_mem_rvalid", 32'(mem_rvalid), 1);
        chk("rd_mem_rdata",  mem_rdata, 32'hDEADBEEF);
        chk("rd_ram_we_off", 32'(ram_we), 0);

        // Reset while an IF read is in flight
        cyc();
        drive(1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0);
        chk("mf_if_gnt", 32'(if_gnt), 1);
        cyc();
        rst_n = 1'b0;
        drive(1'b0, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0);
        chk("mf_rst_if_rv",  32'(if_rvalid), 0);
        chk("mf_rst_rdata",  if_rdata, 0);
        cyc();
        rst_n = 1'b1;
        drive(1'b0, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0);
        chk("mf_rel_rvalid", 32'({if_rvalid, mem_rvalid}), 0);
        chk("mf_rel_if_rd",  if_rdata, 0);
        cyc();
        chk("mf_pipe_empty", 32'({if_rvalid, mem_rvalid}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
